// File: rtl/riscv_defines.sv
// Core-wide definitions: CSR operation encodings and CSR address map entries.
// Latency: n/a (constants only).
// Backpressure: n/a.
package riscv_defines;

    localparam logic [1:0] CSR_OP_NONE  = 2'b00;
    localparam logic [1:0] CSR_OP_WRITE = 2'b01;
    localparam logic [1:0] CSR_OP_SET   = 2'b10;
    localparam logic [1:0] CSR_OP_CLEAR = 2'b11;

    // First of the per-channel MAC-load address CSRs; channel c lives at base+c.
    localparam logic [11:0] CSR_MACLOAD_BASE = 12'h7D0;

endpackage

// File: rtl/macload_agu_ch.sv
// One address channel: two-level loop counters and next-address selection.
// Latency: o_next_addr is combinational from inputs; counters advance on the grant edge.
// Backpressure: none; only ever acts when the arbiter grants it.
// Ports: clk_i/rstn_i clock and async reset; i_clr_n per-channel soft reset;
//        i_grant advance request; i_address..i_outer_skip CSR values; o_next_addr.
module macload_agu_ch
    import riscv_defines::*;
#(
    parameter int AW = 32,
    parameter int CW = 16
) (
    input  logic          clk_i,
    input  logic          rstn_i,
    input  logic          i_clr_n,
    input  logic          i_grant,
    input  logic [AW-1:0] i_address,
    input  logic [AW-1:0] i_stride,
    input  logic [AW-1:0] i_rollback,
    input  logic [AW-1:0] i_outer_rollback,
    input  logic [CW-1:0] i_skip,
    input  logic [CW-1:0] i_outer_skip,
    output logic [AW-1:0] o_next_addr
);

    logic [CW-1:0] r_in;
    logic [CW-1:0] r_out;
    logic          w_inner;
    logic          w_outer;

    // Inner loop still running -> stride; inner done but outer running ->
    // rollback; both done -> outer rollback and restart both loops.
    assign w_inner = (r_in < i_skip);
    assign w_outer = (r_out < i_outer_skip);

    always_comb begin
        if (w_inner) begin
            o_next_addr = i_address + i_stride;
        end else if (w_outer) begin
            o_next_addr = i_address + i_rollback;
        end else begin
            o_next_addr = i_address + i_outer_rollback;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_in  <= '0;
            r_out <= '0;
        end else if (!i_clr_n) begin
            r_in  <= '0;
            r_out <= '0;
        end else if (i_grant) begin
            if (w_inner) begin
                r_in <= r_in + 1'b1;
            end else if (w_outer) begin
                r_in  <= '0;
                r_out <= r_out + 1'b1;
            end else begin
                r_in  <= '0;
                r_out <= '0;
            end
        end
    end

endmodule

// File: rtl/macload_agu.sv
// MAC-load address generator: per-channel loop AGUs sharing one CSR write port.
// Latency: grant and CSR write are combinational in the request cycle; losers queue one deep.
// Backpressure: stall_o (registered) is high while any channel has a queued write.
// Ports: clk_i/rstn_i; id_valid_i/ex_valid_i/update_i requests; csr_rstn_i soft resets;
//        per-channel CSR values in; csr_op_o/csr_address_o/updated_address_o write port;
//        stall_o and sticky overflow_o out.
module macload_agu
    import riscv_defines::*;
#(
    parameter int          NUM_CH   = 2,
    parameter int          AW       = 32,
    parameter int          CW       = 16,
    parameter logic [11:0] CSR_BASE = CSR_MACLOAD_BASE
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic                 id_valid_i,
    input  logic                 ex_valid_i,
    input  logic [NUM_CH-1:0]    update_i,
    input  logic [NUM_CH-1:0]    csr_rstn_i,
    input  logic [NUM_CH*AW-1:0] address_i,
    input  logic [NUM_CH*AW-1:0] stride_i,
    input  logic [NUM_CH*AW-1:0] rollback_i,
    input  logic [NUM_CH*AW-1:0] outer_rollback_i,
    input  logic [NUM_CH*CW-1:0] skip_i,
    input  logic [NUM_CH*CW-1:0] outer_skip_i,
    output logic [AW-1:0]        updated_address_o,
    output logic [1:0]           csr_op_o,
    output logic [11:0]          csr_address_o,
    output logic                 stall_o,
    output logic [NUM_CH-1:0]    overflow_o
);

    localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [NUM_CH-1:0] w_req;
    logic [NUM_CH-1:0] w_cand;
    logic [NUM_CH-1:0] w_gnt;
    logic [NUM_CH-1:0] w_pend_nxt;
    logic [NUM_CH-1:0] w_ovf_nxt;
    logic [AW-1:0]     w_next_addr [NUM_CH];
    logic [IW-1:0]     w_sel;
    logic              w_any;

    logic [NUM_CH-1:0] r_pend;
    logic [NUM_CH-1:0] r_ovf;
    logic              r_stall;

    assign w_req = update_i & {NUM_CH{id_valid_i & ex_valid_i}};

    // A channel held in soft reset never wins; nothing wins during core reset
    // so the write port reads idle while rstn_i is low.
    assign w_cand = (w_req | r_pend) & csr_rstn_i & {NUM_CH{rstn_i}};

    // Fixed priority: lowest index wins.
    always_comb begin
        w_gnt = '0;
        w_any = 1'b0;
        w_sel = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (w_cand[c] && !w_any) begin
                w_gnt[c] = 1'b1;
                w_any    = 1'b1;
                w_sel    = c[IW-1:0];
            end
        end
    end

    always_comb begin
        csr_op_o          = CSR_OP_NONE;
        csr_address_o     = '0;
        updated_address_o = '0;
        if (w_any) begin
            csr_op_o          = CSR_OP_WRITE;
            csr_address_o     = CSR_BASE + {{(12-IW){1'b0}}, w_sel};
            updated_address_o = w_next_addr[w_sel];
        end
    end

    // Queue depth is one per channel: a fresh request arriving while one is
    // already queued (and the channel loses again) is dropped and flagged.
    assign w_pend_nxt = csr_rstn_i & (w_req | r_pend) & ~w_gnt;
    assign w_ovf_nxt  = csr_rstn_i & (r_ovf | (w_req & r_pend & ~w_gnt));

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_pend  <= '0;
            r_ovf   <= '0;
            r_stall <= 1'b0;
        end else begin
            r_pend  <= w_pend_nxt;
            r_ovf   <= w_ovf_nxt;
            r_stall <= |w_pend_nxt;
        end
    end

    assign stall_o    = r_stall;
    assign overflow_o = r_ovf;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        macload_agu_ch #(
            .AW(AW),
            .CW(CW)
        ) u_ch (
            .clk_i            (clk_i),
            .rstn_i           (rstn_i),
            .i_clr_n          (csr_rstn_i[c]),
            .i_grant          (w_gnt[c]),
            .i_address        (address_i[c*AW +: AW]),
            .i_stride         (stride_i[c*AW +: AW]),
            .i_rollback       (rollback_i[c*AW +: AW]),
            .i_outer_rollback (outer_rollback_i[c*AW +: AW]),
            .i_skip           (skip_i[c*CW +: CW]),
            .i_outer_skip     (outer_skip_i[c*CW +: CW]),
            .o_next_addr      (w_next_addr[c])
        );
    end

endmodule

// File: tb/tb_macload_agu.sv
// Bench for macload_agu: directed scenarios followed by random traffic,
// checked against a loop-counter model of each channel and the shared arbiter.
module tb_macload_agu;
    import riscv_defines::*;

    localparam int          NUM_CH   = 2;
    localparam int          AW       = 32;
    localparam int          CW       = 16;
    localparam logic [11:0] CSR_BASE = 12'h7D0;

    logic                 clk_i = 1'b0;
    logic                 rstn_i;
    logic                 id_valid_i;
    logic                 ex_valid_i;
    logic [NUM_CH-1:0]    update_i;
    logic [NUM_CH-1:0]    csr_rstn_i;
    logic [NUM_CH*AW-1:0] address_i;
    logic [NUM_CH*AW-1:0] stride_i;
    logic [NUM_CH*AW-1:0] rollback_i;
    logic [NUM_CH*AW-1:0] outer_rollback_i;
    logic [NUM_CH*CW-1:0] skip_i;
    logic [NUM_CH*CW-1:0] outer_skip_i;
    logic [AW-1:0]        updated_address_o;
    logic [1:0]           csr_op_o;
    logic [11:0]          csr_address_o;
    logic                 stall_o;
    logic [NUM_CH-1:0]    overflow_o;

    // CSR contents per channel
    logic [AW-1:0] t_addr [NUM_CH];
    logic [AW-1:0] t_stride [NUM_CH];
    logic [AW-1:0] t_rb [NUM_CH];
    logic [AW-1:0] t_orb [NUM_CH];
    logic [CW-1:0] t_skip [NUM_CH];
    logic [CW-1:0] t_osk [NUM_CH];

    // reference model state
    int m_in [NUM_CH];
    int m_out [NUM_CH];
    bit m_pend [NUM_CH];
    bit m_ovf [NUM_CH];

    int total = 0;
    int bad = 0;

    logic [1:0]    last_op;
    logic [11:0]   last_csr;
    logic [AW-1:0] last_data;

    always #5 clk_i = ~clk_i;

    always_comb begin
        address_i        = '0;
        stride_i         = '0;
        rollback_i       = '0;
        outer_rollback_i = '0;
        skip_i           = '0;
        outer_skip_i     = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            address_i[c*AW +: AW]        = t_addr[c];
            stride_i[c*AW +: AW]         = t_stride[c];
            rollback_i[c*AW +: AW]       = t_rb[c];
            outer_rollback_i[c*AW +: AW] = t_orb[c];
            skip_i[c*CW +: CW]           = t_skip[c];
            outer_skip_i[c*CW +: CW]     = t_osk[c];
        end
    end

    macload_agu #(
        .NUM_CH(NUM_CH),
        .AW(AW),
        .CW(CW),
        .CSR_BASE(CSR_BASE)
    ) dut (
        .clk_i            (clk_i),
        .rstn_i           (rstn_i),
        .id_valid_i       (id_valid_i),
        .ex_valid_i       (ex_valid_i),
        .update_i         (update_i),
        .csr_rstn_i       (csr_rstn_i),
        .address_i        (address_i),
        .stride_i         (stride_i),
        .rollback_i       (rollback_i),
        .outer_rollback_i (outer_rollback_i),
        .skip_i           (skip_i),
        .outer_skip_i     (outer_skip_i),
        .updated_address_o(updated_address_o),
        .csr_op_o         (csr_op_o),
        .csr_address_o    (csr_address_o),
        .stall_o          (stall_o),
        .overflow_o       (overflow_o)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            m_in[c]   = 0;
            m_out[c]  = 0;
            m_pend[c] = 1'b0;
            m_ovf[c]  = 1'b0;
        end
    endtask

    function automatic logic [NUM_CH-1:0] model_ovf_vec();
        logic [NUM_CH-1:0] v;
        for (int c = 0; c < NUM_CH; c++) v[c] = m_ovf[c];
        return v;
    endfunction

    function automatic bit model_any_pend();
        bit a = 1'b0;
        for (int c = 0; c < NUM_CH; c++) a |= m_pend[c];
        return a;
    endfunction

    // One clock: inputs are already driven (called just after a negedge).
    // Checks the combinational write port, advances the model on the edge,
    // emulates the CSR taking the written address, then checks stall/overflow.
    task automatic cycle();
        int            g;
        int            kind;
        bit            req;
        logic [AW-1:0] ea;
        g    = -1;
        kind = 0;
        ea   = '0;
        #1;
        for (int c = 0; c < NUM_CH; c++) begin
            req = update_i[c] && id_valid_i && ex_valid_i;
            if (g < 0 && csr_rstn_i[c] && (req || m_pend[c])) g = c;
        end
        if (g >= 0) begin
            if (m_in[g] < int'(t_skip[g])) begin
                kind = 1;
                ea   = t_addr[g] + t_stride[g];
            end else if (m_out[g] < int'(t_osk[g])) begin
                kind = 2;
                ea   = t_addr[g] + t_rb[g];
            end else begin
                kind = 3;
                ea   = t_addr[g] + t_orb[g];
            end
        end
        last_op   = csr_op_o;
        last_csr  = csr_address_o;
        last_data = updated_address_o;
        chk("csr_op", csr_op_o, (g >= 0) ? CSR_OP_WRITE : CSR_OP_NONE);
        chk("csr_addr", csr_address_o, (g >= 0) ? 12'(CSR_BASE + g) : 12'h000);
        chk("wdata", updated_address_o, (g >= 0) ? ea : '0);
        @(posedge clk_i);
        for (int c = 0; c < NUM_CH; c++) begin
            req = update_i[c] && id_valid_i && ex_valid_i;
            if (!csr_rstn_i[c]) begin
                m_in[c]   = 0;
                m_out[c]  = 0;
                m_pend[c] = 1'b0;
                m_ovf[c]  = 1'b0;
            end else if (c == g) begin
                m_pend[c] = 1'b0;
                if (kind == 1) begin
                    m_in[c]++;
                end else if (kind == 2) begin
                    m_in[c] = 0;
                    m_out[c]++;
                end else begin
                    m_in[c]  = 0;
                    m_out[c] = 0;
                end
            end else if (req) begin
                if (m_pend[c]) m_ovf[c] = 1'b1;
                m_pend[c] = 1'b1;
            end
        end
        #1;
        if (g >= 0) t_addr[g] = ea;
        chk("stall", stall_o, model_any_pend());
        chk("overflow", overflow_o, model_ovf_vec());
        @(negedge clk_i);
    endtask

    task automatic set_ch(input int c, input logic [AW-1:0] a, input logic [AW-1:0] s,
                          input logic [CW-1:0] sk, input logic [AW-1:0] rb,
                          input logic [CW-1:0] osk, input logic [AW-1:0] orb);
        t_addr[c]   = a;
        t_stride[c] = s;
        t_skip[c]   = sk;
        t_rb[c]     = rb;
        t_osk[c]    = osk;
        t_orb[c]    = orb;
    endtask

    initial begin
        rstn_i     = 1'b0;
        id_valid_i = 1'b0;
        ex_valid_i = 1'b0;
        update_i   = '0;
        csr_rstn_i = '1;
        for (int c = 0; c < NUM_CH; c++) set_ch(c, '0, '0, '0, '0, '0, '0);
        model_reset();
        update_i   = 2'b11;
        id_valid_i = 1'b1;
        ex_valid_i = 1'b1;
        #3;
        chk("rst_op", csr_op_o, CSR_OP_NONE);
        chk("rst_csr", csr_address_o, 12'h000);
        chk("rst_data", updated_address_o, '0);
        chk("rst_stall", stall_o, 1'b0);
        chk("rst_ovf", overflow_o, 2'b00);
        update_i = '0;
        @(negedge clk_i);
        @(negedge clk_i);
        rstn_i = 1'b1;
        @(negedge clk_i);

        // single-level loop with rollback after two strides
        set_ch(0, 32'h100, 32'd4, 16'd2, 32'hFFFF_FFF8, 16'd0, 32'hFFFF_FFF8);
        update_i = 2'b01;
        cycle(); chk("sl_w1", last_data, 32'h104);
        cycle(); chk("sl_w2", last_data, 32'h108);
        cycle(); chk("sl_w3", last_data, 32'h100);

        // two-level loop
        set_ch(0, 32'h0, 32'd1, 16'd1, 32'h10, 16'd1, 32'h100);
        cycle(); chk("tl_w1", last_data, 32'h1);
        cycle(); chk("tl_w2", last_data, 32'h11);
        cycle(); chk("tl_w3", last_data, 32'h12);
        cycle(); chk("tl_w4", last_data, 32'h112);

        // skip=0: rollback every grant
        set_ch(0, 32'h40, 32'd4, 16'd0, 32'h8, 16'd3, 32'h1000);
        cycle(); chk("sk0_w1", last_data, 32'h48);
        cycle(); chk("sk0_w2", last_data, 32'h50);

        // simultaneous requests
        csr_rstn_i = 2'b00;
        update_i   = 2'b00;
        cycle();
        csr_rstn_i = 2'b11;
        set_ch(1, 32'h2000, 32'd8, 16'd5, 32'h0, 16'd0, 32'h0);
        update_i = 2'b11;
        cycle();
        chk("sim_csr0", last_csr, CSR_BASE);
        chk("sim_stall1", stall_o, 1'b1);
        update_i = 2'b00;
        cycle();
        chk("sim_csr1", last_csr, 12'(CSR_BASE + 1));
        chk("sim_data1", last_data, 32'h2008);
        chk("sim_stall0", stall_o, 1'b0);

        // overflow on a queued channel
        update_i = 2'b11;
        cycle();
        cycle();
        chk("ovf_csr0", last_csr, CSR_BASE);
        chk("ovf_set", overflow_o, 2'b10);
        update_i = 2'b00;
        cycle();
        chk("ovf_drain_csr", last_csr, 12'(CSR_BASE + 1));
        cycle();
        chk("ovf_sticky", overflow_o, 2'b10);
        csr_rstn_i = 2'b01;
        cycle();
        chk("ovf_clr", overflow_o, 2'b00);
        csr_rstn_i = 2'b11;

        // soft reset suppresses grant while a request is present
        update_i   = 2'b01;
        csr_rstn_i = 2'b10;
        cycle();
        chk("srst_nogrant", last_op, CSR_OP_NONE);
        csr_rstn_i = 2'b11;

        // ex_valid low: nothing happens
        ex_valid_i = 1'b0;
        update_i   = 2'b11;
        cycle();
        chk("exv0_op", last_op, CSR_OP_NONE);
        ex_valid_i = 1'b1;

        // core reset with a queued write discards it
        cycle();
        chk("prst_stall", stall_o, 1'b1);
        update_i = 2'b00;
        rstn_i   = 1'b0;
        #1;
        chk("prst_stall0", stall_o, 1'b0);
        chk("prst_op", csr_op_o, CSR_OP_NONE);
        model_reset();
        @(negedge clk_i);
        rstn_i = 1'b1;
        cycle();
        chk("prst_nowrite", last_op, CSR_OP_NONE);

        // random traffic
        for (int n = 0; n < 600; n++) begin
            if (n % 60 == 0) begin
                for (int c = 0; c < NUM_CH; c++) begin
                    set_ch(c, $urandom, $urandom_range(0, 64), 16'($urandom_range(0, 3)),
                           $urandom, 16'($urandom_range(0, 2)), $urandom);
                end
            end
            update_i   = 2'($urandom_range(0, 3));
            id_valid_i = ($urandom_range(0, 7) != 0);
            ex_valid_i = ($urandom_range(0, 7) != 0);
            for (int c = 0; c < NUM_CH; c++) csr_rstn_i[c] = ($urandom_range(0, 15) != 0);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
